// File: rtl/rip_const.sv
// Shared types and constants for the memory arbiter and its response router.
package rip_const;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MA} mem_owner_t;

  typedef enum logic {ARB_LOAD, ARB_RUN} arb_state_t;

  localparam int unsigned MEM_BYTE_LANES = 4;

endpackage

// File: rtl/rip_mem_resp_router.sv
// Routes the one-cycle-latency memory read data back to the owner tagged at grant time.
module rip_mem_resp_router
  import rip_const::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  mem_owner_t            tag_i,
  input  logic                  ma_wr_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  ma_rvalid_o,
  output logic [DATA_WIDTH-1:0] ma_rdata_o
);

  mem_owner_t            tag_q;
  logic                  ma_wr_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] ma_rdata_q;

  // Read data arrives in the response cycle, so it is forwarded and captured at once.
  always_comb begin
    if_rvalid_o = (tag_q == OWN_IF);
    ma_rvalid_o = (tag_q == OWN_MA);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
    ma_rdata_o  = (ma_rvalid_o && !ma_wr_q) ? mem_rdata_i : ma_rdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q      <= OWN_NONE;
      ma_wr_q    <= 1'b0;
      if_rdata_q <= '0;
      ma_rdata_q <= '0;
    end else begin
      tag_q      <= tag_i;
      ma_wr_q    <= ma_wr_i;
      if_rdata_q <= if_rdata_o;
      ma_rdata_q <= ma_rdata_o;
    end
  end

endmodule

// File: rtl/rip_mem_arbiter.sv
// Shares the single memory port among loader, memory-access stage and instruction fetch,
// with boot sequencing (load then run) and an IF anti-starvation guard.
module rip_mem_arbiter
  import rip_const::*;
#(
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ld_req,
  input  logic [31:0]           ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  input  logic                  ld_done,
  output logic                  ld_gnt,
  input  logic                  ma_req,
  input  logic [3:0]            ma_we,
  input  logic [31:0]           ma_addr,
  input  logic [DATA_WIDTH-1:0] ma_wdata,
  output logic                  ma_gnt,
  output logic                  ma_rvalid,
  output logic [DATA_WIDTH-1:0] ma_rdata,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  running,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  arb_state_t            state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  run;
  logic                  force_if;
  mem_owner_t            tag;
  logic                  ma_wr;

  // Byte-offset bits and bits above the word address are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[1:0], ld_addr[31:ADDR_WIDTH+2],
                              ma_addr[1:0], ma_addr[31:ADDR_WIDTH+2],
                              if_addr[1:0], if_addr[31:ADDR_WIDTH+2]};

  always_comb begin
    run      = (state_q == ARB_RUN);
    force_if = (starve_q == StarveLim);
    ld_gnt   = !run && ld_req;
    ma_gnt   = run && ma_req && !(force_if && if_req);
    if_gnt   = run && if_req && !ma_gnt;
    mem_en   = ld_gnt || ma_gnt || if_gnt;
    running  = run;

    mem_we    = 4'h0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (ld_gnt) begin
      mem_we    = 4'hF;
      mem_addr  = ld_addr[ADDR_WIDTH+1:2];
      mem_wdata = ld_wdata;
    end else if (ma_gnt) begin
      mem_we    = ma_we;
      mem_addr  = ma_addr[ADDR_WIDTH+1:2];
      mem_wdata = ma_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr[ADDR_WIDTH+1:2];
    end

    // MA writes are tagged too: their response is the write acknowledge.
    tag   = if_gnt ? OWN_IF : (ma_gnt ? OWN_MA : OWN_NONE);
    ma_wr = ma_gnt && (ma_we != 4'h0);

    starve_d = 4'h0;
    if (run && if_req && !if_gnt) begin
      starve_d = force_if ? starve_q : starve_q + 4'h1;
    end

    state_d = state_q;
    if (!run && ld_done) begin
      state_d = ARB_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ARB_LOAD;
      starve_q <= 4'h0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
    end
  end

  rip_mem_resp_router #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_router (
    .clk         (clk),
    .rstn        (rstn),
    .tag_i       (tag),
    .ma_wr_i     (ma_wr),
    .mem_rdata_i (mem_rdata),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .ma_rvalid_o (ma_rvalid),
    .ma_rdata_o  (ma_rdata)
  );

endmodule
